// File: rtl/i2c_byte_assembler.sv
// Groups the I2C receive tap's START/bit/STOP command stream into byte records
// (8 data bits MSB first plus ACK slot), with event pulses and error flags.
module i2c_byte_assembler #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [2:0]       tap_data,
    input  logic             tap_valid,
    output logic [7:0]       byte_data,
    output logic             byte_ack,
    output logic             byte_first,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             evt_start,
    output logic             evt_stop,
    output logic             err_frame,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic [CNT_W-1:0] frame_bytes,
    output logic             busy
);

    localparam logic [2:0]       CMD_START = 3'd1;
    localparam logic [2:0]       CMD_BIT1  = 3'd2;
    localparam logic [2:0]       CMD_BIT0  = 3'd3;
    localparam logic [2:0]       CMD_STOP  = 3'd4;
    localparam logic [CNT_W-1:0] FB_ONE    = CNT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       first_pend;

    logic is_start;
    logic is_stop;
    logic is_bit;
    logic is_illegal;
    logic bit_val;
    logic rec_done;
    logic accept;
    logic load;
    logic drop;

    always_comb begin
        is_start   = tap_valid && (tap_data == CMD_START);
        is_stop    = tap_valid && (tap_data == CMD_STOP);
        is_bit     = tap_valid && ((tap_data == CMD_BIT1) || (tap_data == CMD_BIT0));
        is_illegal = tap_valid && !(is_start || is_stop || is_bit);
        bit_val    = (tap_data == CMD_BIT1);
        rec_done   = (state == SHIFT) && is_bit && (bit_cnt == 4'd8);
        accept     = byte_valid && byte_ready;
        // A completed record only fits if the output slot frees up this cycle.
        load       = rec_done && (!byte_valid || accept);
        drop       = rec_done && !load;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            first_pend  <= 1'b0;
            byte_data   <= '0;
            byte_ack    <= 1'b0;
            byte_first  <= 1'b0;
            byte_valid  <= 1'b0;
            evt_start   <= 1'b0;
            evt_stop    <= 1'b0;
            err_frame   <= 1'b0;
            overflow    <= 1'b0;
            frame_bytes <= '0;
            busy        <= 1'b0;
        end else begin
            evt_start <= is_start;
            evt_stop  <= is_stop && (state == SHIFT);
            err_frame <= is_illegal ||
                         ((state == SHIFT) && (is_start || is_stop) && (bit_cnt != 4'd0));

            if (load) begin
                byte_data  <= shreg;
                byte_ack   <= !bit_val;
                byte_first <= first_pend;
                byte_valid <= 1'b1;
            end else if (accept) begin
                byte_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (is_start) begin
                        state       <= SHIFT;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        first_pend  <= 1'b1;
                        frame_bytes <= '0;
                    end
                end
                SHIFT: begin
                    if (is_start) begin
                        bit_cnt     <= '0;
                        first_pend  <= 1'b1;
                        frame_bytes <= '0;
                    end else if (is_stop) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end else if (is_bit) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt    <= '0;
                            first_pend <= 1'b0;
                            if (frame_bytes != '1) begin
                                frame_bytes <= frame_bytes + FB_ONE;
                            end
                        end else begin
                            shreg   <= {shreg[6:0], bit_val};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_byte_assembler.sv
// Self-checking bench for i2c_byte_assembler: directed table, corner sequences,
// and randomized traffic against a queue-based record model.
module tb_i2c_byte_assembler;

    localparam int unsigned CNT_W  = 2;
    localparam int          FB_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       tap_data = '0;
    logic             tap_valid = 1'b0;
    logic [7:0]       byte_data;
    logic             byte_ack;
    logic             byte_first;
    logic             byte_valid;
    logic             byte_ready = 1'b0;
    logic             evt_start;
    logic             evt_stop;
    logic             err_frame;
    logic             overflow;
    logic             clr_overflow = 1'b0;
    logic [CNT_W-1:0] frame_bytes;
    logic             busy;

    i2c_byte_assembler #(.CNT_W(CNT_W)) dut (
        .clock        (clock),
        .rst          (rst),
        .tap_data     (tap_data),
        .tap_valid    (tap_valid),
        .byte_data    (byte_data),
        .byte_ack     (byte_ack),
        .byte_first   (byte_first),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .evt_start    (evt_start),
        .evt_stop     (evt_stop),
        .err_frame    (err_frame),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .frame_bytes  (frame_bytes),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: bits of the current byte are kept in a queue; a record
    // is formed once nine bit commands have been collected.
    int         m_in_frame = 0;
    int         m_bits[$];
    int         m_first_pend = 0;
    int         m_fb = 0;
    logic [7:0] m_data = '0;
    logic       m_ack = 0, m_first = 0, m_valid = 0, m_ovf = 0;
    logic       m_start = 0, m_stop = 0, m_err = 0;

    task automatic model(input logic r, input logic v, input logic [2:0] d,
                         input logic rdy, input logic c);
        logic accepted, new_rec, dropped;
        int   val;
        if (r) begin
            m_in_frame = 0; m_bits.delete(); m_first_pend = 0; m_fb = 0;
            m_data = '0; m_ack = 0; m_first = 0; m_valid = 0; m_ovf = 0;
            m_start = 0; m_stop = 0; m_err = 0;
            return;
        end
        accepted = m_valid && rdy;
        new_rec = 0; dropped = 0;
        m_start = 0; m_stop = 0; m_err = 0;
        if (v) begin
            if (d == 0 || d > 4) begin
                m_err = 1;
            end else if (d == 1) begin
                m_start = 1;
                if (m_in_frame && m_bits.size() != 0) m_err = 1;
                m_in_frame = 1; m_bits.delete(); m_first_pend = 1; m_fb = 0;
            end else if (m_in_frame && d == 4) begin
                m_stop = 1;
                if (m_bits.size() != 0) m_err = 1;
                m_bits.delete(); m_in_frame = 0;
            end else if (m_in_frame) begin
                m_bits.push_back(d == 2 ? 1 : 0);
                if (m_bits.size() == 9) begin
                    val = 0;
                    for (int i = 0; i < 8; i++) val = val * 2 + m_bits[i];
                    new_rec = 1;
                    if (!m_valid || accepted) begin
                        m_data = val[7:0];
                        m_ack = (m_bits[8] == 0);
                        m_first = (m_first_pend != 0);
                    end else begin
                        dropped = 1;
                    end
                    m_first_pend = 0;
                    m_bits.delete();
                    if (m_fb < FB_MAX) m_fb++;
                end
            end
        end
        if (new_rec && !dropped) m_valid = 1;
        else if (accepted) m_valid = 0;
        if (c) m_ovf = 0;
        if (dropped) m_ovf = 1;
    endtask

    int p_start = 0, p_stop = 0, p_err = 0, p_valid = 0;

    task automatic cyc(input logic r, input logic v, input logic [2:0] d,
                       input logic rdy, input logic c);
        rst = r; tap_valid = v; tap_data = d; byte_ready = rdy; clr_overflow = c;
        model(r, v, d, rdy, c);
        @(posedge clock);
        #1;
        chk("m_valid", byte_valid, m_valid);
        chk("m_data", byte_data, m_data);
        chk("m_ack", byte_ack, m_ack);
        chk("m_first", byte_first, m_first);
        chk("m_evt_start", evt_start, m_start);
        chk("m_evt_stop", evt_stop, m_stop);
        chk("m_err_frame", err_frame, m_err);
        chk("m_overflow", overflow, m_ovf);
        chk("m_frame_bytes", frame_bytes, m_fb);
        chk("m_busy", busy, m_in_frame != 0);
        p_start += evt_start; p_stop += evt_stop; p_err += err_frame; p_valid += byte_valid;
    endtask

    task automatic clear_pulses();
        p_start = 0; p_stop = 0; p_err = 0; p_valid = 0;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    // Sends 8 data bits MSB first then the ACK slot; ready may differ on the slot.
    task automatic send_byte(input logic [7:0] b, input logic ack,
                             input logic rdy_bits, input logic rdy_slot);
        for (int i = 7; i >= 0; i--) cyc(0, 1, b[i] ? 3'd2 : 3'd3, rdy_bits, 0);
        cyc(0, 1, ack ? 3'd3 : 3'd2, rdy_slot, 0);
    endtask

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic       r;
        logic       ev;
        logic [7:0] edata;
        logic       eack;
        logic       efirst;
        logic       estart;
        logic       estop;
        logic       eerr;
        int         efb;
        logic       ebusy;
    } vec_t;

    vec_t tbl[$];

    task automatic t_add(input logic v, input logic [2:0] d, input logic r,
                         input logic ev, input logic [7:0] edata, input logic eack,
                         input logic efirst, input logic estart, input logic estop,
                         input logic eerr, input int efb, input logic ebusy);
        vec_t e;
        e.v = v; e.d = d; e.r = r; e.ev = ev; e.edata = edata; e.eack = eack;
        e.efirst = efirst; e.estart = estart; e.estop = estop; e.eerr = eerr;
        e.efb = efb; e.ebusy = ebusy;
        tbl.push_back(e);
    endtask

    initial begin
        logic [7:0] b;
        int         rv;
        logic       rr, rvld, rrdy, rclr;
        logic [2:0] rd;

        // Address 0xA0 (ACK) then data 0x55 (NACK), then STOP, ready held high.
        t_add(1, 3'd1, 1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1);
        b = 8'hA0;
        for (int i = 7; i >= 0; i--) t_add(1, b[i] ? 3'd2 : 3'd3, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        t_add(1, 3'd3, 1, 1, 8'hA0, 1, 1, 0, 0, 0, 1, 1);
        b = 8'h55;
        for (int i = 7; i >= 0; i--) t_add(1, b[i] ? 3'd2 : 3'd3, 1, 0, 8'hA0, 1, 1, 0, 0, 0, 1, 1);
        t_add(1, 3'd2, 1, 1, 8'h55, 0, 0, 0, 0, 0, 2, 1);
        t_add(1, 3'd4, 1, 0, 8'h55, 0, 0, 0, 1, 0, 2, 0);
        t_add(0, 3'd0, 1, 0, 8'h55, 0, 0, 0, 0, 0, 2, 0);

        rst = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_valid", byte_valid, 0);
        chk("reset_data", byte_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_bytes", frame_bytes, 0);
        do_reset();

        clear_pulses();
        foreach (tbl[k]) begin
            cyc(0, tbl[k].v, tbl[k].d, tbl[k].r, 0);
            chk("t1_valid", byte_valid, tbl[k].ev);
            chk("t1_data", byte_data, tbl[k].edata);
            chk("t1_ack", byte_ack, tbl[k].eack);
            chk("t1_first", byte_first, tbl[k].efirst);
            chk("t1_evt_start", evt_start, tbl[k].estart);
            chk("t1_evt_stop", evt_stop, tbl[k].estop);
            chk("t1_err", err_frame, tbl[k].eerr);
            chk("t1_frame_bytes", frame_bytes, tbl[k].efb);
            chk("t1_busy", busy, tbl[k].ebusy);
        end
        chk("t1_start_count", p_start, 1);
        chk("t1_stop_count", p_stop, 1);

        // Repeated START after four bits, then a full byte 0x3C.
        do_reset();
        clear_pulses();
        cyc(0, 1, 3'd1, 1, 0);
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd3, 1, 0);
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd1, 1, 0);
        chk("rs_err_at_restart", err_frame, 1);
        chk("rs_valid_before", p_valid, 0);
        send_byte(8'h3C, 1, 1, 1);
        chk("rs_data", byte_data, 8'h3C);
        chk("rs_first", byte_first, 1);
        chk("rs_valid", byte_valid, 1);
        cyc(0, 1, 3'd4, 1, 0);
        chk("rs_err_count", p_err, 1);
        chk("rs_start_count", p_start, 2);
        chk("rs_record_count", p_valid, 1);

        // Backpressure: second record is dropped, first held.
        do_reset();
        cyc(0, 1, 3'd1, 0, 0);
        send_byte(8'h11, 1, 0, 0);
        send_byte(8'h22, 1, 0, 0);
        chk("bp_data_held", byte_data, 8'h11);
        chk("bp_valid", byte_valid, 1);
        chk("bp_overflow", overflow, 1);
        cyc(0, 0, 3'd0, 0, 1);
        chk("bp_overflow_cleared", overflow, 0);
        chk("bp_data_still", byte_data, 8'h11);

        // Same-cycle handoff: 9th bit of 0x22 arrives as 0x11 is accepted.
        send_byte(8'h22, 1, 0, 1);
        chk("ho_valid", byte_valid, 1);
        chk("ho_data", byte_data, 8'h22);
        chk("ho_overflow", overflow, 0);
        cyc(0, 1, 3'd4, 1, 0);

        // IDLE noise and illegal codes.
        do_reset();
        clear_pulses();
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd3, 1, 0);
        cyc(0, 1, 3'd4, 1, 0);
        chk("idle_events", p_start + p_stop + p_err + p_valid, 0);
        cyc(0, 1, 3'd6, 1, 0);
        chk("idle_illegal_err", err_frame, 1);
        chk("idle_illegal_busy", busy, 0);
        cyc(0, 1, 3'd1, 1, 0);
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd3, 1, 0);
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd0, 1, 0);
        chk("shift_illegal_err", err_frame, 1);
        cyc(0, 1, 3'd3, 1, 0);
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd3, 1, 0);
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd2, 1, 0);
        cyc(0, 1, 3'd3, 1, 0);
        chk("ill_data", byte_data, 8'hAB);
        chk("ill_ack", byte_ack, 1);
        chk("ill_first", byte_first, 1);
        chk("ill_valid", byte_valid, 1);
        chk("ill_err_count", p_err, 2);

        // Saturation of frame_bytes and reset mid-byte.
        do_reset();
        cyc(0, 1, 3'd1, 1, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), i[0], 1, 1);
        chk("sat_frame_bytes", frame_bytes, FB_MAX);
        cyc(0, 1, 3'd1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 3'd2, 1, 0);
        cyc(1, 1, 3'd2, 1, 0);
        chk("rst_all_outputs",
            {byte_data, byte_ack, byte_first, byte_valid, evt_start, evt_stop,
             err_frame, overflow, frame_bytes, busy}, 0);
        clear_pulses();
        for (int i = 0; i < 5; i++) cyc(0, 1, 3'd2, 1, 0);
        chk("rst_no_record", p_valid, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rv   = $urandom_range(0, 99);
            if (rv < 40) rd = 3'd2;
            else if (rv < 80) rd = 3'd3;
            else if (rv < 86) rd = 3'd1;
            else if (rv < 92) rd = 3'd4;
            else begin
                rv = $urandom_range(0, 3);
                rd = (rv == 0) ? 3'd0 : 3'(4 + rv);
            end
            rvld = ($urandom_range(0, 9) < 7);
            rrdy = ($urandom_range(0, 9) < 6);
            rclr = ($urandom_range(0, 19) == 0);
            rr   = ($urandom_range(0, 199) == 0);
            cyc(rr, rvld, rd, rrdy, rclr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
